// File: rtl/phy_pkg.sv
// phy_pkg: shared sync symbol, lane count and rx alignment state encoding
package phy_pkg;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hBC;
  localparam int NUM_LANES = 4;
  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/phy_rx_sync.sv
// phy_rx_sync: sync-byte training FSM; ports clk, reset_L, data_in, valid_in, resync -> slot, locked
module phy_rx_sync
  import phy_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       resync,
  output logic [1:0] slot,
  output logic       locked
);
  localparam int CW = $clog2(SYNC_COUNT + 1);
  state_t state;
  logic [CW-1:0] sync_cnt;
  logic hit, last;
  assign hit = valid_in && data_in == SYNC_BYTE;
  assign last = int'(sync_cnt) + 1 == SYNC_COUNT;
  assign locked = state == LOCKED;
  always_ff @(posedge clk)
    if (!reset_L || resync) begin
      state <= SEARCH;
      sync_cnt <= '0;
      slot <= '0;
    end else if (state == SEARCH) begin
      slot <= '0;
      sync_cnt <= (hit && !last) ? sync_cnt + 1'b1 : '0;
      if (hit && last) state <= LOCKED;
    end else slot <= slot + 2'd1;
endmodule

// File: rtl/phy_rx_demux.sv
// phy_rx_demux: 4-slot byte deserializer; ports clk, reset_L, data_in, valid_in, resync -> data_out_0..3, valid_out_0..3, active
module phy_rx_demux
  import phy_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       resync,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic [7:0] data_out_3,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic       valid_out_3,
  output logic       active
);
  logic [1:0] slot;
  logic locked, idle, emit;
  logic [7:0] buf_data [NUM_LANES-1];
  logic [NUM_LANES-2:0] buf_valid;
  logic [7:0] fd [NUM_LANES];
  logic [NUM_LANES-1:0] fv;
  logic [7:0] dout [NUM_LANES];
  logic [NUM_LANES-1:0] vout;
  phy_rx_sync #(.SYNC_BYTE(SYNC_BYTE), .SYNC_COUNT(SYNC_COUNT)) u_sync (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .resync(resync), .slot(slot), .locked(locked)
  );
  assign fd = '{buf_data[0], buf_data[1], buf_data[2], data_in};
  assign fv = {valid_in, buf_valid};
  always_comb begin
    idle = &fv;
    for (int k = 0; k < NUM_LANES; k++) idle = idle && fd[k] == SYNC_BYTE;
  end
  assign emit = locked && !resync && slot == 2'd3 && |fv && !idle;
  always_ff @(posedge clk)
    if (!reset_L) begin
      buf_data <= '{default: '0};
      buf_valid <= '0;
      dout <= '{default: '0};
      vout <= '0;
    end else begin
      vout <= emit ? fv : '0;
      for (int k = 0; k < NUM_LANES; k++) if (emit && fv[k]) dout[k] <= fd[k];
      if (locked && !resync && slot != 2'd3) begin
        if (valid_in) buf_data[slot] <= data_in;
        buf_valid[slot] <= valid_in;
      end
    end
  assign {data_out_3, data_out_2, data_out_1, data_out_0} = {dout[3], dout[2], dout[1], dout[0]};
  assign {valid_out_3, valid_out_2, valid_out_1, valid_out_0} = vout;
  assign active = locked;
endmodule

// File: tb/tb_phy_rx_demux.sv
// tb_phy_rx_demux: directed stimulus checked against a frame-queue model of the receiver
module tb_phy_rx_demux;
  logic clk = 0, reset_L = 0, valid_in = 0, resync = 0;
  logic [7:0] data_in = 0;
  logic [7:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic valid_out_0, valid_out_1, valid_out_2, valid_out_3, active;
  int checks = 0, errors = 0;
  bit chk = 0;
  phy_rx_demux dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in), .resync(resync),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .valid_out_3(valid_out_3), .active(active)
  );
  always #5 clk = ~clk;
  bit m_lock;
  int m_run;
  logic [8:0] q[$];
  logic [7:0] m_d [4];
  logic [3:0] m_v;
  bit any_v, all_idle;
  always @(posedge clk) begin
    if (!reset_L) begin
      m_lock = 0; m_run = 0; q.delete(); m_d = '{default: 8'h00}; m_v = 0;
    end else begin
      m_v = 0;
      if (resync) begin
        m_lock = 0; m_run = 0; q.delete();
      end else if (!m_lock) begin
        m_run = (valid_in && data_in == 8'hBC) ? m_run + 1 : 0;
        if (m_run == 4) begin m_lock = 1; m_run = 0; end
      end else begin
        q.push_back({valid_in, data_in});
        if (q.size() == 4) begin
          any_v = 0; all_idle = 1;
          for (int k = 0; k < 4; k++) begin
            any_v |= q[k][8];
            all_idle &= (q[k] == {1'b1, 8'hBC});
          end
          if (any_v && !all_idle)
            for (int k = 0; k < 4; k++) if (q[k][8]) begin m_d[k] = q[k][7:0]; m_v[k] = 1; end
          q.delete();
        end
      end
    end
  end
  task automatic check(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  always @(negedge clk) if (chk) begin
    check("data_out_0", data_out_0, m_d[0]);
    check("data_out_1", data_out_1, m_d[1]);
    check("data_out_2", data_out_2, m_d[2]);
    check("data_out_3", data_out_3, m_d[3]);
    check("valid_out", {4'h0, valid_out_3, valid_out_2, valid_out_1, valid_out_0}, {4'h0, m_v});
    check("active", {7'h0, active}, {7'h0, m_lock});
  end
  task automatic step(input logic v, input logic [7:0] d, input logic r = 0);
    valid_in = v; data_in = d; resync = r;
    @(negedge clk);
  endtask
  task automatic frame(input logic [3:0] v, input logic [31:0] d);
    for (int k = 0; k < 4; k++) step(v[k], d[31-8*k -: 8]);
  endtask
  function automatic logic [7:0] vo();
    return {4'h0, valid_out_3, valid_out_2, valid_out_1, valid_out_0};
  endfunction
  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'($urandom), 8'($urandom));
    check("rst_data", data_out_0 | data_out_1 | data_out_2 | data_out_3, 8'h00);
    check("rst_valid", vo(), 8'h00);
    check("rst_active", {7'h0, active}, 8'h00);
    reset_L = 1; chk = 1;
    for (int i = 0; i < 4; i++) step(1, 8'hBC);
    check("lock_active", {7'h0, active}, 8'h01);
    frame(4'hF, 32'hFFEEDDCC);
    check("f1_d0", data_out_0, 8'hFF);
    check("f1_d3", data_out_3, 8'hCC);
    check("f1_valid", vo(), 8'h0F);
    frame(4'b1101, 32'h11_00_33_44);
    check("part_valid", vo(), 8'h0D);
    check("part_d1", data_out_1, 8'hEE);
    check("part_d0", data_out_0, 8'h11);
    frame(4'hF, 32'hBCBCBCBC);
    check("idle_valid", vo(), 8'h00);
    frame(4'h0, 32'h12345678);
    check("empty_valid", vo(), 8'h00);
    check("empty_d2", data_out_2, 8'h33);
    check("idle_active", {7'h0, active}, 8'h01);
    step(0, 8'h00, 1);
    check("resync_active", {7'h0, active}, 8'h00);
    step(1, 8'hBC); step(1, 8'hBC); step(1, 8'hBC); step(1, 8'h00);
    step(1, 8'hBC); step(1, 8'hBC); step(1, 8'hBC);
    check("broken_nolock", {7'h0, active}, 8'h00);
    step(1, 8'hBC);
    check("broken_lock", {7'h0, active}, 8'h01);
    frame(4'hF, 32'h55667788);
    check("f2_d0", data_out_0, 8'h55);
    check("f2_d3", data_out_3, 8'h88);
    check("f2_valid", vo(), 8'h0F);
    step(1, 8'h01); step(1, 8'h02); step(1, 8'h03); step(1, 8'h04, 1);
    check("rs_valid", vo(), 8'h00);
    check("rs_active", {7'h0, active}, 8'h00);
    check("rs_d0", data_out_0, 8'h55);
    for (int i = 0; i < 4; i++) step(1, 8'hBC);
    frame(4'hF, 32'hA1A2A3A4);
    check("f3_d0", data_out_0, 8'hA1);
    check("f3_d3", data_out_3, 8'hA4);
    check("f3_valid", vo(), 8'h0F);
    step(0, 8'h00);
    check("strobe_end", vo(), 8'h00);
    step(1, 8'h99); step(1, 8'h98);
    reset_L = 0;
    step(1, 8'h97);
    reset_L = 1;
    step(1, 8'h96); step(1, 8'h95);
    check("rst_mid_d0", data_out_0, 8'h00);
    check("rst_mid_active", {7'h0, active}, 8'h00);
    chk = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
